// File: rtl/shift_add_multiplier_if.sv
// ---------------------------------------------------------------------------
// shift_add_multiplier_if
//   Request/response bundle for the sequential shift-and-add multiplier.
//
//   Signals (WIDTH = operand width, product is 2*WIDTH):
//     start   : request to begin a multiply, sampled on the rising clock edge
//     sgn     : 0 = unsigned, 1 = two's-complement signed (sampled with start)
//     a       : multiplicand (sampled with start)
//     b       : multiplier   (sampled with start)
//     busy    : high while an operation is in progress
//     done    : one-cycle pulse when product becomes valid
//     product : result register, holds its value until the next result
//
//   Modports:
//     master : the requester (drives start/sgn/a/b)
//     slave  : the multiplier (drives busy/done/product)
// ---------------------------------------------------------------------------
interface shift_add_multiplier_if #(
  parameter int WIDTH = 32
);

  logic                 start;
  logic                 sgn;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, sgn, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, sgn, a, b,
    output busy, done, product
  );

endinterface

// File: rtl/shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// sixty_four_bit_adder
//   Plain 64-bit adder with carry-in. It is the only adder on the multiplier
//   datapath: accumulation uses c_in = 0, the final two's-complement negate
//   uses ~acc with c_in = 1.
//
//   Ports:
//     a, b : 64-bit addends
//     c_in : carry into bit 0
//     sum  : a + b + c_in, modulo 2^64
// ---------------------------------------------------------------------------
module sixty_four_bit_adder (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        c_in,
  output logic [63:0] sum
);

  assign sum = a + b + {63'd0, c_in};

endmodule

// ---------------------------------------------------------------------------
// shift_add_multiplier
//   Sequential radix-2 shift-and-add multiplier, signed or unsigned.
//
//   Operation:
//     - A start seen in IDLE or DONE latches |a| (zero-extended to 64 bits),
//       |b|, and a negate flag = sgn & (a_msb ^ b_msb). Starts seen while
//       busy are ignored.
//     - CALC runs exactly WIDTH cycles: add the multiplicand into the
//       accumulator when the multiplier LSB is set, then shift multiplicand
//       left and multiplier right.
//     - NEG (only when the negate flag is set) two's-complements the
//       accumulator in one cycle through the same adder.
//     - DONE loads product and pulses done for one cycle. A start in DONE
//       goes straight back to CALC with no bubble.
//
//   Ports:
//     clk : clock, all state updates on the rising edge
//     rst : synchronous, active-high reset; clears all state, aborts any
//           operation in flight, and takes priority over start
//     bus : shift_add_multiplier_if slave modport (start/sgn/a/b in,
//           busy/done/product out)
// ---------------------------------------------------------------------------
module shift_add_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  shift_add_multiplier_if.slave  bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    NEG  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state;
  logic [63:0]          mcand;     // multiplicand, shifts left each step
  logic [63:0]          acc;       // running partial product
  logic [WIDTH-1:0]     mplier;    // multiplier, shifts right each step
  logic [CW-1:0]        count;     // CALC step index, 0..WIDTH-1
  logic                 neg_flag;  // result must be negated after CALC
  logic                 busy_r;
  logic                 done_r;
  logic [2*WIDTH-1:0]   product_r;

  // -------------------------------------------------------------------------
  // Operand magnitudes. The most-negative value maps onto itself, which read
  // as unsigned is exactly 2^(WIDTH-1), so no special case is needed.
  // -------------------------------------------------------------------------
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             accept;

  assign a_neg = bus.sgn & bus.a[WIDTH-1];
  assign b_neg = bus.sgn & bus.b[WIDTH-1];
  assign mag_a = a_neg ? ((~bus.a) + WIDTH'(1)) : bus.a;
  assign mag_b = b_neg ? ((~bus.b) + WIDTH'(1)) : bus.b;

  // Start is honoured only when no operation is in flight.
  assign accept = bus.start & ((state == IDLE) | (state == DONE));

  // -------------------------------------------------------------------------
  // Shared adder. In NEG it computes ~acc + 1; otherwise acc + mcand.
  // -------------------------------------------------------------------------
  logic [63:0] add_a;
  logic [63:0] add_b;
  logic        add_cin;
  logic [63:0] add_sum;
  logic [63:0] step_acc;

  // NOTE: every signal assigned in always_comb gets a default on entry, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    add_a   = acc;
    add_b   = mcand;
    add_cin = 1'b0;
    if (state == NEG) begin
      add_a   = ~acc;
      add_b   = 64'd0;
      add_cin = 1'b1;
    end
  end

  sixty_four_bit_adder u_adder (
    .a    (add_a),
    .b    (add_b),
    .c_in (add_cin),
    .sum  (add_sum)
  );

  // Accumulator value after one CALC step.
  assign step_acc = mplier[0] ? add_sum : acc;

  // -------------------------------------------------------------------------
  // Control and datapath registers. Outputs are registered so that busy and
  // done change exactly on the state transitions.
  // -------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values of its sources.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath registers are reset along with the control state,
      // so an aborted operation leaves nothing stale and product reads 0.
      state     <= IDLE;
      mcand     <= 64'd0;
      acc       <= 64'd0;
      mplier    <= '0;
      count     <= '0;
      neg_flag  <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      product_r <= '0;
    end else begin
      done_r <= 1'b0;

      if (accept) begin
        state    <= CALC;
        mcand    <= {{(64-WIDTH){1'b0}}, mag_a};
        mplier   <= mag_b;
        acc      <= 64'd0;
        count    <= '0;
        neg_flag <= bus.sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        busy_r   <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            busy_r <= 1'b0;
          end

          CALC: begin
            acc    <= step_acc;
            mcand  <= {mcand[62:0], 1'b0};
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
            if (count == LAST_STEP) begin
              if (neg_flag) begin
                state <= NEG;
              end else begin
                // Product loads from the final step's accumulator value.
                state     <= DONE;
                busy_r    <= 1'b0;
                done_r    <= 1'b1;
                product_r <= step_acc[2*WIDTH-1:0];
              end
            end
          end

          NEG: begin
            acc       <= add_sum;
            state     <= DONE;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            product_r <= add_sum[2*WIDTH-1:0];
          end

          DONE: begin
            // A start here was handled by the accept branch above.
            state  <= IDLE;
            busy_r <= 1'b0;
          end

          default: begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.product = product_r;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// tb_shift_add_multiplier
//   Directed bench for shift_add_multiplier (WIDTH = 32). Each operation is
//   started, then observed for a bounded number of edges on the falling
//   clock edge. Edges are numbered from the start-sampling edge as 1, so an
//   unsigned result shows done after edge 33 and a negated one after 34.
// ---------------------------------------------------------------------------
module tb_shift_add_multiplier;

  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  shift_add_multiplier_if #(.WIDTH(WIDTH)) bus ();

  shift_add_multiplier #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Observations collected by watch().
  int          done1;
  int          done2;
  int          pulses;
  int          busy_cnt;
  int          unstable;
  logic        busy_after_rst;
  logic [63:0] prod1;
  logic [63:0] prod2;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present operands for one cycle; returns right after the sampling edge.
  task automatic start_op(input bit s, input logic [31:0] x,
                          input logic [31:0] y);
    @(negedge clk);
    bus.start = 1'b1;
    bus.sgn   = s;
    bus.a     = x;
    bus.b     = y;
    @(posedge clk);
  endtask

  // Observe max_edges falling edges after the sampling edge. Optional
  // stimulus: a stray 7x7 start at inject_k, a 2x2 start at b2b_k, and a
  // one-cycle reset at rst_k (-1 disables each).
  task automatic watch(input int max_edges, input int inject_k,
                       input int b2b_k, input int rst_k);
    logic [63:0] prev;
    prev           = bus.product;
    done1          = -1;
    done2          = -1;
    pulses         = 0;
    busy_cnt       = 0;
    unstable       = 0;
    busy_after_rst = 1'bx;
    prod1          = '0;
    prod2          = '0;
    for (int k = 1; k <= max_edges; k++) begin
      @(negedge clk);
      // Sample outputs first.
      if (bus.busy === 1'b1) begin
        busy_cnt++;
        if (bus.product !== prev) unstable++;
      end
      prev = bus.product;
      if (bus.done === 1'b1) begin
        pulses++;
        if (done1 < 0) begin
          done1 = k;
          prod1 = bus.product;
        end else if (done2 < 0) begin
          done2 = k;
          prod2 = bus.product;
        end
      end
      if (k == rst_k + 1) busy_after_rst = bus.busy;
      // Then drive inputs for the next edge.
      if (k == 1) bus.start = 1'b0;
      if (k == inject_k) begin
        bus.start = 1'b1;
        bus.a     = 32'd7;
        bus.b     = 32'd7;
      end
      if (k == inject_k + 1) bus.start = 1'b0;
      if (k == b2b_k) begin
        bus.start = 1'b1;
        bus.sgn   = 1'b0;
        bus.a     = 32'd2;
        bus.b     = 32'd2;
      end
      if (k == b2b_k + 1) bus.start = 1'b0;
      if (k == rst_k) rst = 1'b1;
      if (k == rst_k + 1) rst = 1'b0;
    end
  endtask

  // One full operation with latency, result, pulse count and stability.
  task automatic run_op(input string tag, input bit s, input logic [31:0] x,
                        input logic [31:0] y, input logic [63:0] exp_prod,
                        input int exp_edge);
    start_op(s, x, y);
    watch(40, -1, -1, -1);
    check({tag, " done edge"}, done1, exp_edge);
    check({tag, " product"}, prod1, exp_prod);
    check({tag, " pulses"}, pulses, 1);
    check({tag, " busy cycles"}, busy_cnt, exp_edge - 1);
    check({tag, " product stable"}, unstable, 0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.sgn   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    check("reset product", bus.product, 0);

    // Reset wins over a simultaneous start.
    bus.start = 1'b1;
    bus.a     = 32'd3;
    bus.b     = 32'd5;
    @(negedge clk);
    check("rst over start busy", bus.busy, 0);
    bus.start = 1'b0;
    rst       = 1'b0;

    run_op("u 3x5", 1'b0, 32'd3, 32'd5, 64'h0000_0000_0000_000F, 33);
    @(negedge clk);
    check("u 3x5 product held", bus.product, 64'd15);

    run_op("u max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           64'hFFFF_FFFE_0000_0001, 33);
    run_op("s -3x5", 1'b1, 32'hFFFF_FFFD, 32'd5,
           64'hFFFF_FFFF_FFFF_FFF1, 34);
    run_op("s minxmin", 1'b1, 32'h8000_0000, 32'h8000_0000,
           64'h4000_0000_0000_0000, 33);
    run_op("s -3x-5", 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 64'd15, 33);
    run_op("s 0x-5", 1'b1, 32'd0, 32'hFFFF_FFFB, 64'd0, 34);
    run_op("u 0x9", 1'b0, 32'd0, 32'd9, 64'd0, 33);

    // Stray start during CALC cycle 5 must be ignored.
    start_op(1'b0, 32'd3, 32'd5);
    watch(75, 5, -1, -1);
    check("ignore done edge", done1, 33);
    check("ignore product", prod1, 64'd15);
    check("ignore pulses", pulses, 1);
    check("ignore busy cycles", busy_cnt, 32);

    // Start held in the DONE cycle chains straight into the next multiply.
    start_op(1'b0, 32'd3, 32'd5);
    watch(75, -1, 33, -1);
    check("b2b first edge", done1, 33);
    check("b2b first product", prod1, 64'd15);
    check("b2b second edge", done2, 66);
    check("b2b second product", prod2, 64'd4);
    check("b2b pulses", pulses, 2);
    check("b2b busy cycles", busy_cnt, 64);
    check("b2b product stable", unstable, 0);

    // Reset in CALC cycle 10 aborts the operation.
    start_op(1'b0, 32'd3, 32'd5);
    watch(40, -1, -1, 10);
    check("abort busy", busy_after_rst, 0);
    check("abort pulses", pulses, 0);
    check("abort product", bus.product, 64'd0);

    run_op("u 6x7", 1'b0, 32'd6, 32'd7, 64'd42, 33);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
